// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO result registers
// Ports: clk; reset (synchronous, active-low); start/MDUOp/A/B request inputs;
// busy high while a mult/div runs; HI/LO current result registers.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [3:0]  cnt;
    logic [2:0]  op;
    logic [31:0] a, b, ua, ub, q, r, hi_n, lo_n;
    logic [63:0] prod;
    logic        go, done, wr;

    assign busy = state == BUSY;
    assign go   = state == IDLE && start && MDUOp >= 3'd1 && MDUOp <= 3'd4;
    assign done = state == BUSY && cnt == 4'd1;

    always_comb begin
        state_n = go ? BUSY : done ? IDLE : state;
    end

    // signed divide works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000
    always_comb begin
        ua   = op == 3'd3 && a[31] ? -a : a;
        ub   = op == 3'd3 && b[31] ? -b : b;
        q    = ua / ub;
        r    = ua % ub;
        prod = op == 3'd1 ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'd0, a} * {32'd0, b};
        wr   = op <= 3'd2 || b != 32'd0;
        hi_n = op <= 3'd2 ? prod[63:32] : op == 3'd3 && a[31] ? -r : r;
        lo_n = op <= 3'd2 ? prod[31:0] : op == 3'd3 && (a[31] ^ b[31]) ? -q : q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            a     <= '0;
            b     <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_n;
            if (go) begin
                op  <= MDUOp;
                a   <= A;
                b   <= B;
                cnt <= MDUOp <= 3'd2 ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end else if (busy) begin
                cnt <= cnt - 4'd1;
            end
            if (state == IDLE && start && MDUOp == 3'd5) HI <= A;
            if (state == IDLE && start && MDUOp == 3'd6) LO <= A;
            if (done && wr) begin
                HI <= hi_n;
                LO <= lo_n;
            end
        end
    end
endmodule
